// File: rtl/mem_subsystem_ctrl.sv
// MAR/MDR plus a wait-stated word RAM behind a rd/wr request, busy/done handshake.
// Define MEM_ADDR_CHECK_EN to add the addr_err output.
module mem_subsystem_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              mem_rd,
  input  logic              mem_wr,
  output logic              mem_busy,
  output logic              mem_done,
  output logic [DATA_W-1:0] BusMuxInMDR,
  output logic [ADDR_W-1:0] mar_q
`ifdef MEM_ADDR_CHECK_EN
  ,
  output logic              addr_err
`endif
);

  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic              r_op_wr;
  logic              w_op_nx;
  logic [ADDR_W-1:0] r_mar;
  logic [ADDR_W-1:0] w_mar_nx;
  logic [DATA_W-1:0] r_mdr;
  logic [DATA_W-1:0] w_mdr_nx;
  logic              r_busy;
  logic              r_done;
  logic              w_we;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rdata;

  logic [DATA_W-1:0] r_mem [DEPTH];

  assign w_in_range = ({1'b0, r_mar} < DEPTH_L);
  assign w_idx      = r_mar[IDX_W-1:0];
  assign w_rdata    = r_mem[w_idx];

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_op_nx    = r_op_wr;
    w_mar_nx   = r_mar;
    w_mdr_nx   = r_mdr;
    w_we       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (MARin) w_mar_nx = BusMuxOut[ADDR_W-1:0];
        if (MDRin) w_mdr_nx = BusMuxOut;
        if (mem_rd ^ mem_wr) begin
          w_state_nx = S_WAIT;
          w_cnt_nx   = CNT_INIT;
          w_op_nx    = mem_wr;
        end
      end
      S_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - 1'b1;
        end else begin
          w_state_nx = S_DONE;
          // out-of-range writes vanish, reads return zero
          if (r_op_wr) w_we = w_in_range;
          else w_mdr_nx = w_in_range ? w_rdata : '0;
        end
      end
      S_DONE: w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op_wr <= 1'b0;
      r_mar   <= '0;
      r_mdr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_op_wr <= w_op_nx;
      r_mar   <= w_mar_nx;
      r_mdr   <= w_mdr_nx;
      r_busy  <= (w_state_nx != S_IDLE);
      r_done  <= (w_state_nx == S_DONE);
    end
  end

  always_ff @(posedge clock) begin
    if (w_we) r_mem[w_idx] <= r_mdr;
  end

`ifdef MEM_ADDR_CHECK_EN
  logic r_aerr;
  logic w_aerr_nx;

  assign w_aerr_nx =
    ((r_state == S_IDLE) && mem_rd && mem_wr) ||
    ((r_state == S_WAIT) && (r_cnt == '0) && !w_in_range);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_aerr <= 1'b0;
    else r_aerr <= w_aerr_nx;
  end

  assign addr_err = r_aerr;
`endif

  assign mem_busy    = r_busy;
  assign mem_done    = r_done;
  assign BusMuxInMDR = r_mdr;
  assign mar_q       = r_mar;

endmodule

// File: tb/tb_mem_subsystem_ctrl.sv
// Bench for mem_subsystem_ctrl: a 512-word and a 256-word instance share stimulus
// and are checked every cycle against a transaction-level model.
module tb_mem_subsystem_ctrl;

  localparam int WS = 2;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] BusMuxOut = '0;
  logic        MARin = 1'b0;
  logic        MDRin = 1'b0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;

  logic        busy_a, done_a, busy_b, done_b;
  logic [31:0] mdr_a, mdr_b;
  logic [8:0]  mar_a, mar_b;
`ifdef MEM_ADDR_CHECK_EN
  logic        err_a, err_b;
`endif

  int checks = 0;
  int errs = 0;

  always #5 clock = ~clock;

  mem_subsystem_ctrl #(
    .DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_STATES(WS)
  ) u_a (
    .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut),
    .MARin(MARin), .MDRin(MDRin), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_busy(busy_a), .mem_done(done_a),
    .BusMuxInMDR(mdr_a), .mar_q(mar_a)
`ifdef MEM_ADDR_CHECK_EN
    , .addr_err(err_a)
`endif
  );

  mem_subsystem_ctrl #(
    .DATA_W(32), .ADDR_W(9), .DEPTH(256), .WAIT_STATES(WS)
  ) u_b (
    .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut),
    .MARin(MARin), .MDRin(MDRin), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_busy(busy_b), .mem_done(done_b),
    .BusMuxInMDR(mdr_b), .mar_q(mar_b)
`ifdef MEM_ADDR_CHECK_EN
    , .addr_err(err_b)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: per instance, edges left until the access plus a done flag.
  int          dep [2] = '{512, 256};
  logic [8:0]  m_mar [2];
  logic [31:0] m_mdr [2];
  logic        m_wr [2];
  logic        m_done [2];
  logic        m_err [2];
  int          m_t [2];
  logic [31:0] mm [2][512];

  always @(posedge clock or negedge clear) begin
    for (int k = 0; k < 2; k++) begin
      if (!clear) begin
        m_mar[k] = '0; m_mdr[k] = '0; m_wr[k] = 1'b0;
        m_done[k] = 1'b0; m_err[k] = 1'b0; m_t[k] = 0;
      end else begin
        m_err[k] = 1'b0;
        if (m_done[k]) begin
          m_done[k] = 1'b0;
        end else if (m_t[k] > 0) begin
          m_t[k]--;
          if (m_t[k] == 0) begin
            m_done[k] = 1'b1;
            m_err[k] = (int'(m_mar[k]) >= dep[k]);
            if (int'(m_mar[k]) < dep[k]) begin
              if (m_wr[k]) mm[k][m_mar[k]] = m_mdr[k];
              else m_mdr[k] = mm[k][m_mar[k]];
            end else if (!m_wr[k]) begin
              m_mdr[k] = '0;
            end
          end
        end else begin
          if (MARin) m_mar[k] = BusMuxOut[8:0];
          if (MDRin) m_mdr[k] = BusMuxOut;
          if (mem_rd != mem_wr) begin
            m_t[k] = WS + 1;
            m_wr[k] = mem_wr;
          end else if (mem_rd) begin
            m_err[k] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("busy_a", 32'(busy_a), 32'(m_t[0] > 0 || m_done[0]));
    chk("done_a", 32'(done_a), 32'(m_done[0]));
    chk("mdr_a", mdr_a, m_mdr[0]);
    chk("mar_a", 32'(mar_a), 32'(m_mar[0]));
    chk("busy_b", 32'(busy_b), 32'(m_t[1] > 0 || m_done[1]));
    chk("done_b", 32'(done_b), 32'(m_done[1]));
    chk("mdr_b", mdr_b, m_mdr[1]);
    chk("mar_b", 32'(mar_b), 32'(m_mar[1]));
`ifdef MEM_ADDR_CHECK_EN
    chk("err_a", 32'(err_a), 32'(m_err[0]));
    chk("err_b", 32'(err_b), 32'(m_err[1]));
`endif
  end

  task automatic idle_in();
    MARin = 1'b0; MDRin = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  task automatic drive(input logic [31:0] bus, input logic mi, input logic di,
                       input logic rd, input logic wr);
    @(negedge clock);
    BusMuxOut = bus; MARin = mi; MDRin = di; mem_rd = rd; mem_wr = wr;
    @(negedge clock);
    idle_in();
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 1;
    while (!done_a && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk(nm, 32'(n), 32'(WS + 2));
  endtask

  task automatic op(input string nm, input logic [31:0] bus, input logic mi,
                    input logic di, input logic rd, input logic wr);
    drive(bus, mi, di, rd, wr);
    wait_done(nm);
  endtask

  task automatic wr_word(input logic [8:0] a, input logic [31:0] d);
    drive(32'(a), 1'b1, 1'b0, 1'b0, 1'b0);
    op("lat_wr", d, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_mdr", mdr_a, 32'd0);
    chk("rst_mar", 32'(mar_a), 32'd0);
    #2 clear = 1'b1;

    wr_word(9'h000, 32'h0BADF00D);
    wr_word(9'h010, 32'h0);
    wr_word(9'h1FF, 32'h12345678);

    // write then read back at address 5
    drive(32'h5, 1'b1, 1'b0, 1'b0, 1'b0);
    op("lat_wr5", 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mdr_clr", mdr_a, 32'h0);
    op("lat_rd5", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rd5_a", mdr_a, 32'hDEADBEEF);
    chk("rd5_b", mdr_b, 32'hDEADBEEF);

    // MAR load in the request cycle; 0x1FF is out of range for u_b
    op("lat_rd1ff", 32'h1FF, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rd1ff_a", mdr_a, 32'h12345678);
    chk("rd1ff_b", mdr_b, 32'h0);
    chk("mar1ff", 32'(mar_a), 32'h1FF);

    // loads and a write request during WAIT are ignored
    @(negedge clock);
    BusMuxOut = 32'h10; MARin = 1'b1; mem_rd = 1'b1;
    @(negedge clock);
    BusMuxOut = 32'h7; MARin = 1'b1; MDRin = 1'b1; mem_rd = 1'b0; mem_wr = 1'b1;
    @(negedge clock);
    @(negedge clock);
    idle_in();
    @(negedge clock);
    chk("ovl_done", 32'(done_a), 32'd1);
    chk("ovl_mar", 32'(mar_a), 32'h10);
    chk("ovl_mdr", mdr_a, 32'h0);
    @(negedge clock);
    @(negedge clock);
    chk("ovl_idle", 32'(busy_a), 32'd0);

    // reset in the first WAIT cycle aborts the write
    drive(32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    BusMuxOut = 32'hA5A5A5A5; MDRin = 1'b1; mem_wr = 1'b1;
    @(negedge clock);
    idle_in();
    #2 clear = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_mdr", mdr_a, 32'd0);
    chk("abort_mar", 32'(mar_a), 32'd0);
    @(negedge clock);
    chk("abort_done", 32'(done_a), 32'd0);
    #2 clear = 1'b1;
    op("lat_rd10", 32'h10, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rd10_a", mdr_a, 32'h0);
    chk("rd10_b", mdr_b, 32'h0);

    // 0x100 is beyond u_b's 256 words
    drive(32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
    op("lat_wr100", 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1);
    op("lat_rd100", 32'h100, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rd100_a", mdr_a, 32'hFFFFFFFF);
    chk("rd100_b", mdr_b, 32'h0);
    op("lat_rd0", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rd0_a", mdr_a, 32'h0BADF00D);
    chk("rd0_b", mdr_b, 32'h0BADF00D);

    // rd and wr together: no access
    drive(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef MEM_ADDR_CHECK_EN
    chk("coll_err", 32'(err_a), 32'd1);
`endif
    for (int i = 0; i < 3; i++) begin
      chk("coll_busy", 32'(busy_a), 32'd0);
      chk("coll_done", 32'(done_a), 32'd0);
      @(negedge clock);
    end
    chk("coll_mdr", mdr_a, 32'h0BADF00D);

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
